// File: rtl/serial_rx_fifo_pkg.sv
// Shared definitions for the serial receive/transmit octet buffers.
// Octet width and the buffer depth legality check.
package serial_rx_fifo_pkg;

    localparam int OCTET_W = 8;

    function automatic bit depth_ok(input int d);
        return (d >= 2) && (d <= 256) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/serial_rx_fifo_mem.sv
// Octet storage: one synchronous write port, one asynchronous read port.
// Not reset, so it can map to distributed logic or a RAM primitive.
module serial_rx_fifo_mem
    import serial_rx_fifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [OCTET_W-1:0]   wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [OCTET_W-1:0]   rdata
);

    logic [OCTET_W-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/serial_rx_fifo.sv
// Receive-side first-word-fall-through octet buffer with sticky overrun.
// Pointers carry a wrap bit above the storage index to tell full from empty.
module serial_rx_fifo
    import serial_rx_fifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_wr,
    input  logic [OCTET_W-1:0]   i_data,
    output logic                 o_valid,
    output logic [OCTET_W-1:0]   o_data,
    input  logic                 i_rd,
    output logic [ADDR_BITS:0]   o_count,
    output logic                 o_full,
    output logic                 o_overrun,
    input  logic                 i_clr_ovr
);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("serial_rx_fifo: DEPTH must be a power of two in 2..256");
    end

    localparam logic [ADDR_BITS:0] ONE     = (ADDR_BITS + 1)'(1);
    localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS + 1)'(DEPTH);

    logic [ADDR_BITS:0] wr_ptr;
    logic [ADDR_BITS:0] rd_ptr;
    logic [ADDR_BITS:0] count_q;
    logic [ADDR_BITS:0] count_d;
    logic               full_q;
    logic               ovr_q;
    logic               pop;
    logic               push;
    logic               drop;

    assign o_valid = (wr_ptr != rd_ptr);
    assign pop     = o_valid && i_rd;
    // A pop in the same cycle frees the slot a full buffer needs.
    assign push    = i_wr && (!full_q || pop);
    assign drop    = i_wr && full_q && !pop;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE;
            end
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_W);
            if (drop) begin
                ovr_q <= 1'b1;
            end else if (i_clr_ovr) begin
                ovr_q <= 1'b0;
            end
        end
    end

    serial_rx_fifo_mem #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .i_clk (i_clk),
        .we    (push),
        .waddr (wr_ptr[ADDR_BITS-1:0]),
        .wdata (i_data),
        .raddr (rd_ptr[ADDR_BITS-1:0]),
        .rdata (o_data)
    );

    assign o_count   = count_q;
    assign o_full    = full_q;
    assign o_overrun = ovr_q;

endmodule
